instr_scan_decode: RTL and testbench
====================================

# instr_scan_decode

Parametrised instruction fetch-and-decode sequencer. On a start pulse it reads `count` consecutive 32-bit MIPS words from the shared `mem` block, beginning at `base_addr` with a configurable stride. It classifies each word as R, I or J format, splits it into fields, and presents one decoded instruction at a time on a valid/ready output port. It replaces the fixed 11-word, display-only instruction dump with a synthesisable unit that has backpressure, configurable memory read latency and per-format statistics.

## Interface
- `ADDR_W`, default 32: memory address width.
- `CNT_W`, default 8: width of the instruction count and of the statistics counters.
- `STRIDE`, default 4: address increment per instruction, in bytes.
- `RD_LAT`, default 0: memory read latency in cycles (legal values 0..2). A value of 0 means `mem_rdata` is valid in the same cycle as the address.
- `clk  in  1`: clock. One clock domain only.
- `reset_n  in  1`: reset, asynchronous, active-low.
- `start  in  1`: single-cycle request to begin a scan. Ignored while `busy` is 1.
- `base_addr  in  ADDR_W`: first address to fetch. Sampled on an accepted `start`.
- `count  in  CNT_W`: number of instructions to fetch. Sampled on an accepted `start`.
- `mem_addr  out  ADDR_W`: address to `mem`.
- `mem_read  out  1`: read strobe to `mem`.
- `mem_write  out  1`: write strobe to `mem`. Constant 0.
- `mem_wdata  out  32`: write data to `mem`. Constant 0.
- `mem_rdata  in  32`: read data from `mem`.
- `out_valid  out  1`, `out_ready  in  1`: output handshake.
- `out_fmt  out  2`: 0 = R, 1 = I, 2 = J.
- `out_pc  out  ADDR_W`: address of the decoded word.
- `out_op  out  6`: bits [31:26].
- `out_rs  out  5`: bits [25:21].
- `out_rt  out  5`: bits [20:16].
- `out_rd  out  5`: bits [15:11].
- `out_shamt  out  5`: bits [10:6].
- `out_funct  out  6`: bits [5:0].
- `out_imm  out  16`: bits [15:0].
- `out_target  out  26`: bits [25:0].
- `busy  out  1`: 1 whenever the FSM is not in IDLE.
- `done  out  1`: one-cycle pulse at the end of a scan.
- `n_r`, `n_i`, `n_j`  out  CNT_W each: per-format counts of accepted instructions.

## Operation
- FSM states: IDLE, REQ, WAIT, OUT, DONE.
- IDLE:
  - On `start`, latch `pc = base_addr` and `rem = count`, and clear `n_r`, `n_i`, `n_j`.
  - If `count` is 0, go to DONE. Otherwise go to REQ.
- REQ:
  - Drive `mem_addr = pc` and `mem_read = 1`.
  - If `RD_LAT` is 0, capture `mem_rdata` this cycle and go to OUT.
  - Otherwise go to WAIT.
- WAIT:
  - Hold `mem_addr` and `mem_read` for `RD_LAT` cycles.
  - Capture `mem_rdata` on the last of those cycles, then go to OUT.
- Classification of the captured word:
  - op == 0: R format.
  - op == 2 or op == 3: J format.
  - Any other op: I format.
  - All field outputs are driven regardless of format; the consumer selects fields by `out_fmt`.
- OUT:
  - `out_valid = 1`. Data, fields and `out_pc` stay stable until the handshake completes.
  - On `out_valid && out_ready`: increment the counter for that format; set `pc = pc + STRIDE`, wrapping modulo 2^ADDR_W; set `rem = rem - 1`.
  - If the new `rem` is 0, go to DONE. Otherwise go to REQ.
- DONE: assert `done` for one cycle, then go to IDLE.
- Statistics counters hold their values after DONE until the next accepted `start`. They wrap modulo 2^CNT_W.
- `start` while `busy` is 1: no effect, and scan state is not disturbed.
- `reset_n` low at any time, including mid-scan:
  - FSM returns to IDLE immediately.
  - All outputs go to 0: `mem_read`, `out_valid`, `busy`, `done`, all fields, `out_pc`, counters and `mem_addr`.
  - The scan in progress is abandoned and nothing is delivered after release.

## Timing
- Fetch-to-output latency: `out_valid` rises `RD_LAT + 1` cycles after the cycle that enters REQ.
- Throughput with `out_ready` held high: one instruction per `RD_LAT + 2` cycles.
- First REQ is the cycle after the accepted `start`.
- `done` rises the cycle after the final handshake. When `count` is 0, `done` rises the cycle after `start`.
- `busy` rises the cycle after an accepted `start` and falls the cycle after `done`.
- `mem_read` is 1 only in REQ and WAIT. The memory is never accessed while an output is stalled.

## Structure
- Shared package `instr_pkg`:
  - `fmt_t` encoding: R = 0, I = 1, J = 2.
  - Opcode constants: `OP_RTYPE = 0`, `OP_J = 2`, `OP_JAL = 3`.
  - Field bit-position constants.
  - Shared with the ALU/control blocks.
- One combinational sub-module, `instr_field_decode`, maps a 32-bit word to `fmt` and all fields.
- The FSM, counters and output register live in the top module.

## Test plan
- `RD_LAT = 0`, words 0x00221820, 0x8D280004, 0x08000100 at 0x28, 0x2C, 0x30; `count = 3`, `out_ready = 1`. Expect:
  - (R, op 0, rs 1, rt 2, rd 3, funct 32, pc 0x28)
  - (I, op 35, rs 9, rt 8, imm 4)
  - (J, target 0x100)
  - `n_r = n_i = n_j = 1`; `done` 7 cycles after `start`.
- 0x0C000040 (jal) decodes as J, target 0x40. 0x3C010010 (lui) decodes as I, op 15, rt 1, imm 16.
- Backpressure: `out_ready` low for 5 cycles in OUT. Fields stay stable and `mem_read` stays 0 during the stall; exactly one handshake follows.
- `RD_LAT = 2`, `ADDR_W = 8`, `base_addr = 0xFC`, `count = 2`. `mem_addr` reads 0xFC then 0x00 (wrap), each held 3 cycles.
- `count = 0`: `done` the cycle after `start`, no `mem_read`, counters 0. A `start` while busy is ignored, and the original scan delivers its full `count`.
- `reset_n` pulsed low during WAIT of instruction 2 of 4: all outputs 0 immediately, IDLE after release, no further `out_valid`.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared MIPS instruction-format definitions: format encoding, opcodes and field positions.
// Used by the scan/decode sequencer and by the ALU/control blocks.
package instr_pkg;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } fmt_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;

    localparam int unsigned OP_LSB     = 26;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned TARGET_LSB = 0;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned TARGET_W = 26;

    typedef struct packed {
        fmt_t                fmt;
        logic [OP_W-1:0]     op;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    shamt;
        logic [FUNCT_W-1:0]  funct;
        logic [IMM_W-1:0]    imm;
        logic [TARGET_W-1:0] target;
    } instr_dec_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of a 32-bit MIPS word into its format and every field.
module instr_field_decode
    import instr_pkg::*;
(
    input  logic [31:0] word,
    output instr_dec_t  dec
);

    always_comb begin
        dec        = '0;
        dec.op     = word[OP_LSB     +: OP_W];
        dec.rs     = word[RS_LSB     +: REG_W];
        dec.rt     = word[RT_LSB     +: REG_W];
        dec.rd     = word[RD_LSB     +: REG_W];
        dec.shamt  = word[SHAMT_LSB  +: REG_W];
        dec.funct  = word[FUNCT_LSB  +: FUNCT_W];
        dec.imm    = word[IMM_LSB    +: IMM_W];
        dec.target = word[TARGET_LSB +: TARGET_W];
        if (dec.op == OP_RTYPE) begin
            dec.fmt = FMT_R;
        end else if (dec.op == OP_J || dec.op == OP_JAL) begin
            dec.fmt = FMT_J;
        end else begin
            dec.fmt = FMT_I;
        end
    end

endmodule

// File: rtl/instr_scan_decode.sv
// Fetch-and-decode sequencer: reads `count` words from memory starting at `base_addr`,
// decodes each and hands them out over valid/ready with per-format statistics.
module instr_scan_decode
    import instr_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned STRIDE = 4,
    parameter int unsigned RD_LAT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_fmt,
    output logic [ADDR_W-1:0] out_pc,
    output logic [5:0]        out_op,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_funct,
    output logic [15:0]       out_imm,
    output logic [25:0]       out_target,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  n_r,
    output logic [CNT_W-1:0]  n_i,
    output logic [CNT_W-1:0]  n_j
);

    localparam int unsigned WAIT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  rem;
    logic [WAIT_W-1:0] wcnt;
    instr_dec_t        dec_c;
    instr_dec_t        out_q;
    logic              start_acc;
    logic              capture;
    logic              handshake;

    instr_field_decode u_decode (
        .word (mem_rdata),
        .dec  (dec_c)
    );

    assign mem_write  = 1'b0;
    assign mem_wdata  = '0;
    // Address is the scan pointer itself; it only moves on a handshake, so it is stable through REQ/WAIT.
    assign mem_addr   = pc;
    assign out_fmt    = out_q.fmt;
    assign out_op     = out_q.op;
    assign out_rs     = out_q.rs;
    assign out_rt     = out_q.rt;
    assign out_rd     = out_q.rd;
    assign out_shamt  = out_q.shamt;
    assign out_funct  = out_q.funct;
    assign out_imm    = out_q.imm;
    assign out_target = out_q.target;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        start_acc = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = (count == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (RD_LAT == 0) begin
                    capture = 1'b1;
                    state_d = S_OUT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt == WAIT_W'(RD_LAT - 1)) begin
                    capture = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    handshake = 1'b1;
                    state_d   = (rem == CNT_W'(1)) ? S_DONE : S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath, statistics and registered handshake/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= '0;
            rem       <= '0;
            wcnt      <= '0;
            out_q     <= '0;
            out_pc    <= '0;
            n_r       <= '0;
            n_i       <= '0;
            n_j       <= '0;
            mem_read  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (start_acc) begin
                pc  <= base_addr;
                rem <= count;
                n_r <= '0;
                n_i <= '0;
                n_j <= '0;
            end
            if (state == S_WAIT) begin
                wcnt <= wcnt + WAIT_W'(1);
            end else begin
                wcnt <= '0;
            end
            if (capture) begin
                out_q  <= dec_c;
                out_pc <= pc;
            end
            if (handshake) begin
                pc  <= pc + ADDR_W'(STRIDE);
                rem <= rem - CNT_W'(1);
                case (out_q.fmt)
                    FMT_R:   n_r <= n_r + CNT_W'(1);
                    FMT_I:   n_i <= n_i + CNT_W'(1);
                    FMT_J:   n_j <= n_j + CNT_W'(1);
                    default: ;
                endcase
            end
            mem_read  <= (state_d == S_REQ) || (state_d == S_WAIT);
            out_valid <= (state_d == S_OUT);
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_instr_scan_decode.sv
// Bench for instr_scan_decode: a zero-latency 32-bit instance and a two-cycle 8-bit-address instance.
module tb_instr_scan_decode;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } fields_t;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        fields_t     exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance 0: ADDR_W=32, RD_LAT=0 ----------------
    logic        rst0_n, start0, ready0;
    logic [31:0] base0, mem_addr0, mem_wdata0, mem_rdata0, out_pc0;
    logic [7:0]  count0, nr0, ni0, nj0;
    logic        mem_read0, mem_write0, out_valid0, busy0, done0;
    logic [1:0]  out_fmt0;
    logic [5:0]  op0, funct0;
    logic [4:0]  rs0, rt0, rd0, shamt0;
    logic [15:0] imm0;
    logic [25:0] target0;
    logic [31:0] mem0 [64];

    assign mem_rdata0 = mem0[mem_addr0[7:2]];

    instr_scan_decode dut0 (
        .clk(clk), .reset_n(rst0_n), .start(start0), .base_addr(base0), .count(count0),
        .mem_addr(mem_addr0), .mem_read(mem_read0), .mem_write(mem_write0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0), .out_valid(out_valid0), .out_ready(ready0), .out_fmt(out_fmt0),
        .out_pc(out_pc0), .out_op(op0), .out_rs(rs0), .out_rt(rt0), .out_rd(rd0), .out_shamt(shamt0),
        .out_funct(funct0), .out_imm(imm0), .out_target(target0), .busy(busy0), .done(done0),
        .n_r(nr0), .n_i(ni0), .n_j(nj0)
    );

    // ---------------- instance 2: ADDR_W=8, RD_LAT=2 ----------------
    logic        rst2_n, start2, ready2;
    logic [7:0]  base2, mem_addr2, out_pc2;
    logic [31:0] mem_wdata2, mem_rdata2;
    logic [7:0]  count2, nr2, ni2, nj2;
    logic        mem_read2, mem_write2, out_valid2, busy2, done2;
    logic [1:0]  out_fmt2;
    logic [5:0]  op2, funct2;
    logic [4:0]  rs2, rt2, rd2, shamt2;
    logic [15:0] imm2;
    logic [25:0] target2;
    logic [31:0] mem2 [64];
    int          hold2 = 0;

    // Read data is only valid once the address has been held for RD_LAT further cycles.
    always @(posedge clk) hold2 <= mem_read2 ? hold2 + 1 : 0;
    assign mem_rdata2 = (hold2 == 2) ? mem2[mem_addr2[7:2]] : 32'hDEAD_BEEF;

    instr_scan_decode #(.ADDR_W(8), .CNT_W(8), .STRIDE(4), .RD_LAT(2)) dut2 (
        .clk(clk), .reset_n(rst2_n), .start(start2), .base_addr(base2), .count(count2),
        .mem_addr(mem_addr2), .mem_read(mem_read2), .mem_write(mem_write2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .out_valid(out_valid2), .out_ready(ready2), .out_fmt(out_fmt2),
        .out_pc(out_pc2), .out_op(op2), .out_rs(rs2), .out_rt(rt2), .out_rd(rd2), .out_shamt(shamt2),
        .out_funct(funct2), .out_imm(imm2), .out_target(target2), .busy(busy2), .done(done2),
        .n_r(nr2), .n_i(ni2), .n_j(nj2)
    );

    vec_t tbl [5];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic fields_t mkf(input int fmt, input int op, input int rs, input int rt, input int rd,
                                    input int shamt, input int funct, input int imm, input int target);
        fields_t f;
        f.fmt = 2'(fmt);  f.op = 6'(op);  f.rs = 5'(rs);  f.rt = 5'(rt);  f.rd = 5'(rd);
        f.shamt = 5'(shamt);  f.funct = 6'(funct);  f.imm = 16'(imm);  f.target = 26'(target);
        return f;
    endfunction

    // Reference decode from the instruction-format rules, using plain shifts and masks.
    function automatic fields_t model(input logic [31:0] w);
        fields_t     f;
        int unsigned u;
        u        = w;
        f.op     = 6'(u >> 26);
        f.rs     = 5'((u >> 21) & 31);
        f.rt     = 5'((u >> 16) & 31);
        f.rd     = 5'((u >> 11) & 31);
        f.shamt  = 5'((u >> 6) & 31);
        f.funct  = 6'(u & 63);
        f.imm    = 16'(u & 65535);
        f.target = 26'(u % (1 << 26));
        if (f.op == 6'd0) f.fmt = 2'd0;
        else if (f.op == 6'd2 || f.op == 6'd3) f.fmt = 2'd2;
        else f.fmt = 2'd1;
        return f;
    endfunction

    function automatic fields_t obs0();
        fields_t f;
        f = {out_fmt0, op0, rs0, rt0, rd0, shamt0, funct0, imm0, target0};
        return f;
    endfunction

    function automatic fields_t obs2();
        fields_t f;
        f = {out_fmt2, op2, rs2, rt2, rd2, shamt2, funct2, imm2, target2};
        return f;
    endfunction

    task automatic run_table(input logic [31:0] base, input int first, input int n, input logic [23:0] exp_cnt);
        int idx;
        int done_at;
        idx     = first;
        done_at = 0;
        ready0  = 1'b1;
        start0  = 1'b1; base0 = base; count0 = 8'(n);
        tick();
        start0  = 1'b0;
        for (int t = 1; t <= 4 * n + 6; t++) begin
            if (out_valid0) begin
                if (idx < first + n) begin
                    check($sformatf("tbl%0d_fields", idx), obs0(), tbl[idx].exp);
                    check($sformatf("tbl%0d_pc", idx), out_pc0, tbl[idx].pc);
                end else begin
                    check("tbl_extra_valid", out_valid0, 1'b0);
                end
                idx++;
            end
            if (done0 && done_at == 0) done_at = t;
            if (done_at != 0 && t == done_at + 1) check("tbl_busy_fall", busy0, 1'b0);
            tick();
        end
        check("tbl_done_latency", done_at, 2 * n + 1);
        check("tbl_delivered", idx - first, n);
        check("tbl_counters", {nr0, ni0, nj0}, exp_cnt);
    endtask

    // Scan on instance 0 against a queue-based model; optional random backpressure and a start poke while busy.
    task automatic scan0(input logic [31:0] base, input int cnt, input bit rand_ready, input bit poke);
        fields_t     qf [$];
        logic [31:0] qpc [$];
        logic [31:0] a;
        fields_t     f;
        fields_t     snap;
        logic [31:0] snap_pc;
        int          er, ei, ej, got;
        bit          stalled, finished;
        er = 0; ei = 0; ej = 0; got = 0; stalled = 0; finished = 0;
        for (int k = 0; k < cnt; k++) begin
            a = base + 32'(4 * k);
            f = model(mem0[(a >> 2) % 64]);
            qf.push_back(f);
            qpc.push_back(a);
            if (f.fmt == 2'd0) er++; else if (f.fmt == 2'd1) ei++; else ej++;
        end
        start0 = 1'b1; base0 = base; count0 = 8'(cnt);
        tick();
        start0 = 1'b0;
        for (int t = 0; t < 400 && !finished; t++) begin
            if (poke && t == 2) begin
                start0 = 1'b1; base0 = 32'h0; count0 = 8'd5;
            end else begin
                start0 = 1'b0;
            end
            if (stalled) begin
                check("stall_stable", {out_valid0, obs0(), out_pc0}, {1'b1, snap, snap_pc});
                check("stall_no_read", mem_read0, 1'b0);
            end
            ready0 = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid0 && ready0) begin
                if (qf.size() == 0) begin
                    check("scan_extra_out", out_valid0, 1'b0);
                end else begin
                    check("scan_fields", obs0(), qf.pop_front());
                    check("scan_pc", out_pc0, qpc.pop_front());
                end
                got++;
            end
            stalled = out_valid0 && !ready0;
            snap    = obs0();
            snap_pc = out_pc0;
            if (done0) finished = 1;
            else tick();
        end
        start0 = 1'b0;
        check("scan_finished", finished, 1'b1);
        check("scan_count", got, cnt);
        check("scan_counters", {nr0, ni0, nj0}, {8'(er), 8'(ei), 8'(ej)});
        tick();
        check("scan_idle", busy0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        fields_t     f;
        int          seen;
        bit          exp_rd, exp_vd, exp_dn;
        int          ph, inst;

        tbl[0] = '{32'h00221820, 32'h28, mkf(0, 0,  1, 2, 3, 0, 32, 'h1820, 'h0221820)};
        tbl[1] = '{32'h8D280004, 32'h2C, mkf(1, 35, 9, 8, 0, 0, 4,  'h0004, 'h1280004)};
        tbl[2] = '{32'h08000100, 32'h30, mkf(2, 2,  0, 0, 0, 4, 0,  'h0100, 'h0000100)};
        tbl[3] = '{32'h0C000040, 32'h34, mkf(2, 3,  0, 0, 0, 1, 0,  'h0040, 'h0000040)};
        tbl[4] = '{32'h3C010010, 32'h38, mkf(1, 15, 0, 1, 0, 0, 16, 'h0010, 'h0010010)};

        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            case ($urandom_range(0, 3))
                0: w[31:26] = 6'd0;
                1: w[31:26] = 6'($urandom_range(2, 3));
                default: ;
            endcase
            mem0[i] = w;
            mem2[i] = $urandom;
        end
        for (int i = 0; i < 5; i++) mem0[10 + i] = tbl[i].word;

        rst0_n = 1'b0; rst2_n = 1'b0;
        start0 = 1'b0; base0 = '0; count0 = '0; ready0 = 1'b0;
        start2 = 1'b0; base2 = '0; count2 = '0; ready2 = 1'b0;
        repeat (2) tick();
        check("reset0", {mem_read0, out_valid0, busy0, done0, mem_addr0, out_pc0, obs0(),
                         nr0, ni0, nj0, mem_write0, mem_wdata0}, '0);
        check("reset2", {mem_read2, out_valid2, busy2, done2, mem_addr2, out_pc2, obs2(),
                         nr2, ni2, nj2, mem_write2, mem_wdata2}, '0);
        rst0_n = 1'b1; rst2_n = 1'b1;
        tick();

        // Table: R/I/J example, then jal and lui.
        run_table(32'h28, 0, 3, {8'd1, 8'd1, 8'd1});
        run_table(32'h34, 3, 2, {8'd0, 8'd1, 8'd1});

        // Backpressure: five stalled cycles in OUT, then one handshake.
        ready0 = 1'b0;
        start0 = 1'b1; base0 = 32'h2C; count0 = 8'd1;
        tick();
        start0 = 1'b0;
        seen = 0;
        while (!out_valid0 && seen < 10) begin
            tick();
            seen++;
        end
        check("bp_valid_rose", out_valid0, 1'b1);
        f = obs0();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {out_valid0, mem_read0, done0, obs0(), out_pc0}, {1'b1, 1'b0, 1'b0, f, 32'h2C});
        end
        check("bp_fields", f, tbl[1].exp);
        ready0 = 1'b1;
        tick();
        check("bp_after_hs", {out_valid0, done0, nr0, ni0, nj0}, {1'b0, 1'b1, 8'd0, 8'd1, 8'd0});
        tick();
        check("bp_idle", {out_valid0, busy0, ni0}, {1'b0, 1'b0, 8'd1});

        // Zero-length scan clears the counters and never touches memory.
        start0 = 1'b1; base0 = 32'h28; count0 = 8'd0;
        tick();
        start0 = 1'b0;
        check("cnt0_done", {done0, busy0, mem_read0, out_valid0, nr0, ni0, nj0},
                           {1'b1, 1'b1, 1'b0, 1'b0, 24'd0});
        tick();
        check("cnt0_idle", {done0, busy0, mem_read0}, 3'b000);

        // Start while busy is ignored; randomized scans with backpressure.
        scan0(32'h28, 3, 1'b0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            scan0(32'($urandom_range(0, 40) * 4), $urandom_range(1, 8), 1'b1, 1'b0);
        end

        // RD_LAT=2 with 8-bit addresses: wrap from 0xFC to 0x00, cycle-exact trace.
        ready2 = 1'b1;
        start2 = 1'b1; base2 = 8'hFC; count2 = 8'd2;
        tick();
        start2 = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            ph     = (t - 1) % 4;
            inst   = (t - 1) / 4;
            exp_rd = (inst < 2) && (ph < 3);
            exp_vd = (inst < 2) && (ph == 3);
            exp_dn = (t == 9);
            check($sformatf("wrap_t%0d", t),
                  {mem_read2, mem_read2 ? mem_addr2 : 8'h00, out_valid2, done2},
                  {exp_rd, exp_rd ? ((inst == 0) ? 8'hFC : 8'h00) : 8'h00, exp_vd, exp_dn});
            if (exp_vd && out_valid2) begin
                check($sformatf("wrap_data%0d", inst), {out_pc2, obs2()},
                      {(inst == 0) ? 8'hFC : 8'h00, model(mem2[(inst == 0) ? 63 : 0])});
            end
            tick();
        end

        // Reset during the wait of the second of four instructions.
        start2 = 1'b1; base2 = 8'h10; count2 = 8'd4;
        tick();
        start2 = 1'b0;
        for (int t = 1; t < 6; t++) tick();
        check("rst_pre_wait", {mem_read2, busy2, out_valid2, mem_addr2}, {1'b1, 1'b1, 1'b0, 8'h14});
        rst2_n = 1'b0;
        #1;
        check("rst_all_zero", {mem_read2, out_valid2, busy2, done2, mem_addr2, out_pc2, obs2(),
                               nr2, ni2, nj2}, '0);
        tick();
        rst2_n = 1'b1;
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (out_valid2 || busy2 || mem_read2) seen++;
        end
        check("rst_no_activity", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
